// File: rtl/qsys_td_pio_pkg.sv
// rtl/qsys_td_pio_pkg.sv - register offsets and edge-type codes shared by the Qsys PIO blocks
package qsys_td_pio_pkg;

  localparam logic [1:0] PIO_OFF_DATA    = 2'd0;
  localparam logic [1:0] PIO_OFF_DIR     = 2'd1;
  localparam logic [1:0] PIO_OFF_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_OFF_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/qsys_td_sync_edge.sv
// rtl/qsys_td_sync_edge.sv - input synchroniser plus per-bit edge detector
module qsys_td_sync_edge
  import qsys_td_pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_FALL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      data_d <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      data_d <= data_in;
    end
  end

  assign data_in = sync_q[SYNC_STAGES-1];
  // data_d resets to 0, so an input already high out of reset reads as a rising edge
  assign rise = data_in & ~data_d;
  assign fall = ~data_in & data_d;

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign edge_det = rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_det = fall;
    end else begin : g_any
      assign edge_det = rise | fall;
    end
  endgenerate

endmodule

// File: rtl/qsys_td_key_pio_in.sv
// rtl/qsys_td_key_pio_in.sv - Avalon-MM input PIO with edge capture and maskable level irq
module qsys_td_key_pio_in
  import qsys_td_pio_pkg::*;
#(
  parameter int               WIDTH          = 4,
  parameter int               EDGE_TYPE      = EDGE_FALL,
  parameter int               SYNC_STAGES    = 2,
  parameter logic [WIDTH-1:0] IRQ_MASK_RESET = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  qsys_td_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .data_in  (data_in),
    .edge_det (edge_det)
  );

  assign wr_en        = chipselect & ~write_n;
  assign cap_clr      = (wr_en && address == PIO_OFF_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_OFF_DATA:    rd_mux[WIDTH-1:0] = data_in;
      PIO_OFF_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      PIO_OFF_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= IRQ_MASK_RESET;
      edge_capture <= '0;
      readdata     <= '0;
    end else begin
      if (wr_en && address == PIO_OFF_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
      // a fresh edge wins over a coincident write-1-to-clear
      edge_capture <= edge_det | (edge_capture & ~cap_clr);
      readdata     <= rd_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule
